// File: rtl/map105_sreg_timer.sv
// Mapper 105 (NES-EVENT) register front-end: MMC1-style serial register
// loader, power-on PRG unlock sequence and the event countdown timer / IRQ.
module map105_sreg_timer #(
  parameter int         TMR_BITS = 30,
  parameter logic [4:0] CTRL_RST = 5'h0C
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cpu_cyc_i,
  input  logic                cpu_wr_i,
  input  logic [1:0]          cpu_a_i,
  input  logic [7:0]          cpu_d_i,
  input  logic [3:0]          dip_i,
  output logic [4:0]          reg_ctrl_o,
  output logic [4:0]          reg_chr0_o,
  output logic [4:0]          reg_chr1_o,
  output logic [4:0]          reg_prg_o,
  output logic                prg_lock_o,
  output logic                irq_o,
  output logic [TMR_BITS-1:0] tmr_o
);

  typedef enum logic [1:0] {
    S_LOCK0 = 2'd0,
    S_LOCK1 = 2'd1,
    S_RUN   = 2'd2
  } init_e;

  localparam logic [4:0] SHIFT_EMPTY = 5'b10000;
  localparam logic [4:0] CHR0_RST    = 5'h10;

  logic [4:0]          shift_q, shift_d;
  logic                last_wr_q, last_wr_d;
  logic [4:0]          ctrl_q, ctrl_d;
  logic [4:0]          chr0_q, chr0_d;
  logic [4:0]          chr1_q, chr1_d;
  logic [4:0]          prg_q, prg_d;
  init_e               state_q, state_d;
  logic                prg_lock_q, prg_lock_d;
  logic [TMR_BITS-1:0] tmr_q, tmr_d;
  logic                irq_q, irq_d;

  logic                accept_s;
  logic                load_s;
  logic                chr0_load_s;
  logic [4:0]          load_val_s;
  logic                tmr_clear_s;
  logic [TMR_BITS-1:0] tmr_inc_s;
  logic [TMR_BITS-1:0] target_s;
  logic                d_unused_s;

  // A write is only taken when the previous CPU cycle was not also a write
  // (RMW instructions issue two back-to-back writes; only the first counts).
  assign accept_s    = cpu_cyc_i & cpu_wr_i & ~last_wr_q;
  assign load_s      = accept_s & ~cpu_d_i[7] & shift_q[0];
  assign load_val_s  = {cpu_d_i[0], shift_q[4:1]};
  assign chr0_load_s = load_s & (cpu_a_i == 2'd1);
  assign tmr_inc_s   = tmr_q + {{(TMR_BITS-1){1'b0}}, 1'b1};
  assign target_s    = {1'b1, dip_i, {(TMR_BITS-5){1'b0}}};
  assign d_unused_s  = ^cpu_d_i[6:1];

  // Serial shift register and destination register loading.
  always_comb begin
    shift_d   = shift_q;
    ctrl_d    = ctrl_q;
    chr0_d    = chr0_q;
    chr1_d    = chr1_q;
    prg_d     = prg_q;
    last_wr_d = cpu_cyc_i ? cpu_wr_i : last_wr_q;
    if (accept_s) begin
      if (cpu_d_i[7]) begin
        // Reset write: drop any partial bits and force PRG mode 3.
        shift_d = SHIFT_EMPTY;
        ctrl_d  = ctrl_q | 5'h0C;
      end else if (shift_q[0]) begin
        // Sentinel reached bit 0: this is the fifth bit, commit it.
        shift_d = SHIFT_EMPTY;
        case (cpu_a_i)
          2'd0:    ctrl_d = load_val_s;
          2'd1:    chr0_d = load_val_s;
          2'd2:    chr1_d = load_val_s;
          2'd3:    prg_d  = load_val_s;
          default: ctrl_d = ctrl_q;
        endcase
      end else begin
        shift_d = {cpu_d_i[0], shift_q[4:1]};
      end
    end else begin
      shift_d = shift_q;
    end
  end

  // Power-on unlock sequence: bit 4 of register 1 must be loaded 0 then 1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOCK0: begin
        if (chr0_load_s && !load_val_s[4]) begin
          state_d = S_LOCK1;
        end else begin
          state_d = S_LOCK0;
        end
      end
      S_LOCK1: begin
        if (chr0_load_s && load_val_s[4]) begin
          state_d = S_RUN;
        end else begin
          state_d = S_LOCK1;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_LOCK0;
    endcase
    prg_lock_d = (state_d != S_RUN);
  end

  // Event timer: the I bit (old or being written) holds it clear, which also
  // makes a clear on the terminal-count cycle win over the IRQ set.
  always_comb begin
    tmr_d       = tmr_q;
    irq_d       = irq_q;
    tmr_clear_s = chr0_q[4] | chr0_d[4];
    if (tmr_clear_s) begin
      tmr_d = {TMR_BITS{1'b0}};
      irq_d = 1'b0;
    end else if ((state_q == S_RUN) && cpu_cyc_i) begin
      tmr_d = tmr_inc_s;
      irq_d = irq_q | (tmr_inc_s == target_s);
    end else begin
      tmr_d = tmr_q;
      irq_d = irq_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q    <= SHIFT_EMPTY;
      last_wr_q  <= 1'b0;
      ctrl_q     <= CTRL_RST;
      chr0_q     <= CHR0_RST;
      chr1_q     <= 5'h00;
      prg_q      <= 5'h00;
      state_q    <= S_LOCK0;
      prg_lock_q <= 1'b1;
      tmr_q      <= {TMR_BITS{1'b0}};
      irq_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      last_wr_q  <= last_wr_d;
      ctrl_q     <= ctrl_d;
      chr0_q     <= chr0_d;
      chr1_q     <= chr1_d;
      prg_q      <= prg_d;
      state_q    <= state_d;
      prg_lock_q <= prg_lock_d;
      tmr_q      <= tmr_d;
      irq_q      <= irq_d;
    end
  end

  assign reg_ctrl_o = ctrl_q;
  assign reg_chr0_o = chr0_q;
  assign reg_chr1_o = chr1_q;
  assign reg_prg_o  = prg_q;
  assign prg_lock_o = prg_lock_q;
  assign irq_o      = irq_q;
  assign tmr_o      = tmr_q;

endmodule

// File: tb/tb_map105_sreg_timer.sv
// Randomised bench for map105_sreg_timer against a behavioural model that
// keeps the pending serial bits in a queue and the timer as a plain integer.
module tb_map105_sreg_timer;

  localparam int TB = 10;
  localparam int unsigned TMASK = (32'd1 << TB) - 32'd1;

  logic          clk = 1'b0;
  logic          rst, cyc, wr;
  logic [1:0]    a;
  logic [7:0]    d;
  logic [3:0]    dip;
  logic [4:0]    reg_ctrl, reg_chr0, reg_chr1, reg_prg;
  logic          prg_lock, irq;
  logic [TB-1:0] tmr;

  map105_sreg_timer #(.TMR_BITS(TB), .CTRL_RST(5'h0C)) dut (
    .clk_i(clk), .rst_i(rst), .cpu_cyc_i(cyc), .cpu_wr_i(wr),
    .cpu_a_i(a), .cpu_d_i(d), .dip_i(dip),
    .reg_ctrl_o(reg_ctrl), .reg_chr0_o(reg_chr0), .reg_chr1_o(reg_chr1),
    .reg_prg_o(reg_prg), .prg_lock_o(prg_lock), .irq_o(irq), .tmr_o(tmr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [4:0]  m_reg [4];
  bit          m_bits[$];
  bit          m_last;
  int          m_stage;   // 0,1 = locked steps, 2 = running
  int unsigned m_tmr;
  bit          m_irq;

  function automatic int unsigned target_of(input logic [3:0] sw);
    return (32'd1 << (TB - 1)) | (32'(sw) << (TB - 5));
  endfunction

  task automatic model_reset();
    m_reg[0] = 5'h0C; m_reg[1] = 5'h10; m_reg[2] = 5'h00; m_reg[3] = 5'h00;
    m_bits.delete();
    m_last = 1'b0; m_stage = 0; m_tmr = 0; m_irq = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic c, input logic w,
                            input logic [1:0] aa, input logic [7:0] dd, input logic [3:0] sw);
    logic       old_b4;
    bit         old_run, acc, chr0_load;
    logic [4:0] v;
    if (r) begin
      model_reset();
      return;
    end
    old_b4    = m_reg[1][4];
    old_run   = (m_stage == 2);
    acc       = c && w && !m_last;
    chr0_load = 1'b0;
    v         = 5'h00;
    if (c) m_last = w;
    if (acc) begin
      if (dd[7]) begin
        m_bits.delete();
        m_reg[0] = m_reg[0] | 5'h0C;
      end else if (m_bits.size() == 4) begin
        v = {dd[0], m_bits[3], m_bits[2], m_bits[1], m_bits[0]};
        m_reg[aa] = v;
        m_bits.delete();
        chr0_load = (aa == 2'd1);
      end else begin
        m_bits.push_back(dd[0]);
      end
    end
    if (chr0_load) begin
      if (m_stage == 0 && !v[4]) m_stage = 1;
      else if (m_stage == 1 && v[4]) m_stage = 2;
    end
    if (old_b4 || m_reg[1][4]) begin
      m_tmr = 0;
      m_irq = 1'b0;
    end else if (old_run && c) begin
      m_tmr = (m_tmr + 32'd1) & TMASK;
      if (m_tmr == target_of(sw)) m_irq = 1'b1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic compare_all();
    check_eq("reg_ctrl", 32'(reg_ctrl), 32'(m_reg[0]));
    check_eq("reg_chr0", 32'(reg_chr0), 32'(m_reg[1]));
    check_eq("reg_chr1", 32'(reg_chr1), 32'(m_reg[2]));
    check_eq("reg_prg",  32'(reg_prg),  32'(m_reg[3]));
    check_eq("prg_lock", 32'(prg_lock), 32'(m_stage != 2));
    check_eq("irq",      32'(irq),      32'(m_irq));
    check_eq("tmr",      32'(tmr),      m_tmr);
  endtask

  task automatic tick(input logic r, input logic c, input logic w,
                      input logic [1:0] aa, input logic [7:0] dd);
    rst = r; cyc = c; wr = w; a = aa; d = dd;
    @(posedge clk);
    model_step(r, c, w, aa, dd, dip);
    @(negedge clk);
    compare_all();
    rst = 1'b0; cyc = 1'b0; wr = 1'b0;
  endtask

  task automatic wr_cpu(input logic [1:0] aa, input logic [7:0] dd);
    tick(1'b0, 1'b1, 1'b1, aa, dd);
    tick(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic load(input logic [1:0] aa, input logic [4:0] v);
    for (int i = 0; i < 5; i++) wr_cpu(aa, {7'd0, v[i]});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          guard;
    int unsigned tgt;
    logic [7:0]  rd;
    rst = 1'b1; cyc = 1'b0; wr = 1'b0; a = 2'd0; d = 8'h00; dip = 4'd0;
    @(negedge clk);
    tick(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    check_eq("rst_ctrl", 32'(reg_ctrl), 32'h0C);
    check_eq("rst_chr0", 32'(reg_chr0), 32'h10);
    check_eq("rst_lock", 32'(prg_lock), 32'd1);
    check_eq("rst_irq",  32'(irq), 32'd0);
    check_eq("rst_tmr",  32'(tmr), 32'd0);

    // Five bits LSB first into register 3.
    load(2'd3, 5'b01101);
    check_eq("prg_load", 32'(reg_prg), 32'h0D);

    // Back-to-back write: second one is dropped.
    tick(1'b0, 1'b1, 1'b1, 2'd3, 8'h01);
    tick(1'b0, 1'b1, 1'b1, 2'd3, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
    wr_cpu(2'd3, 8'h01); wr_cpu(2'd3, 8'h00); wr_cpu(2'd3, 8'h01);
    check_eq("rmw_noload", 32'(reg_prg), 32'h0D);
    wr_cpu(2'd3, 8'h01);
    check_eq("rmw_load", 32'(reg_prg), 32'h1B);

    // Reset write in the middle of a shift.
    load(2'd0, 5'h01);
    check_eq("ctrl_load", 32'(reg_ctrl), 32'h01);
    wr_cpu(2'd0, 8'h01); wr_cpu(2'd0, 8'h00); wr_cpu(2'd0, 8'h01);
    wr_cpu(2'd0, 8'h80);
    check_eq("ctrl_or0c", 32'(reg_ctrl), 32'h0D);
    load(2'd0, 5'h12);
    check_eq("ctrl_clean", 32'(reg_ctrl), 32'h12);

    // Unlock sequence.
    load(2'd1, 5'h00);
    check_eq("lock_step1", 32'(prg_lock), 32'd1);
    load(2'd1, 5'h10);
    check_eq("lock_run", 32'(prg_lock), 32'd0);
    load(2'd1, 5'h00);
    check_eq("lock_run2", 32'(prg_lock), 32'd0);

    // Count to the terminal value with dip = 0.
    guard = 0;
    while (!m_irq && guard < 4000) begin
      tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 2'd0, 8'h00);
      guard++;
    end
    check_eq("irq_rise", 32'(irq), 32'd1);
    check_eq("irq_tmr", 32'(tmr), 32'd512);

    // Acknowledge, restart with random dip, clear on the terminal cycle.
    load(2'd1, 5'h10);
    check_eq("ack_irq", 32'(irq), 32'd0);
    load(2'd1, 5'h00);
    dip = 4'($urandom_range(0, 15));
    tgt = target_of(dip);
    for (int i = 0; i < 4; i++) wr_cpu(2'd1, 8'h00);
    guard = 0;
    while (m_tmr != tgt - 32'd1 && guard < 3000) begin
      tick(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
      guard++;
    end
    check_eq("pre_term_tmr", 32'(tmr), tgt - 32'd1);
    tick(1'b0, 1'b1, 1'b1, 2'd1, 8'h01);
    check_eq("term_irq", 32'(irq), 32'd0);
    check_eq("term_tmr", 32'(tmr), 32'd0);
    check_eq("term_chr0", 32'(reg_chr0), 32'h10);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic c, w;
      if ($urandom_range(0, 99) == 0) dip = 4'($urandom_range(0, 15));
      c  = ($urandom_range(0, 2) != 0);
      w  = c && ($urandom_range(0, 2) == 0);
      rd = 8'($urandom);
      if ($urandom_range(0, 7) != 0) rd[7] = 1'b0;
      tick(1'($urandom_range(0, 499) == 0), c, w, 2'($urandom_range(0, 3)), rd);
    end

    // Reset in the middle of a count and a shift.
    wr_cpu(2'd0, 8'h80);
    load(2'd1, 5'h00); load(2'd1, 5'h10); load(2'd1, 5'h00);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
    wr_cpu(2'd3, 8'h01); wr_cpu(2'd3, 8'h01);
    tick(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    check_eq("mid_rst_ctrl", 32'(reg_ctrl), 32'h0C);
    check_eq("mid_rst_chr0", 32'(reg_chr0), 32'h10);
    check_eq("mid_rst_chr1", 32'(reg_chr1), 32'h00);
    check_eq("mid_rst_prg",  32'(reg_prg),  32'h00);
    check_eq("mid_rst_lock", 32'(prg_lock), 32'd1);
    check_eq("mid_rst_irq",  32'(irq), 32'd0);
    check_eq("mid_rst_tmr",  32'(tmr), 32'd0);
    load(2'd3, 5'h15);
    check_eq("post_rst_load", 32'(reg_prg), 32'h15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
